mips_exec_decode: RTL and testbench
===================================

// Module: mips_exec_decode
// PURPOSE
//  Main decoder, ALU-control decoder and 32-bit ALU for the single-issue MIPS core, in one registered block.
//  - Decodes opcode into the 10-bit control word and, via ALUOp plus funct, into a 4-bit ALU op.
//  - Selects operand B (register or sign-extended immediate) and computes result and zero flag.
//  - All outputs are registered, so the block acts as the decode/execute boundary register.
// PARAMETERS
//  W  32  datapath width (operands, result, sign-extension target)
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   synchronous, active-high reset
//  in_valid  in   1   instruction fields and operands valid this cycle
//  opcode    in   6   instr[31:26]
//  funct     in   6   instr[5:0]
//  imm16     in   16  instr[15:0]
//  rdata1    in   W   operand A (rs)
//  rdata2    in   W   rt value; operand B when ALUSrc=0
//  out_valid out  1   registered in_valid
//  ctrl      out  10  [0]RegDst [1]RegWrite [2]ALUSrc [3]ALUOp1 [4]ALUOp0 [5]MemRead [6]MemWrite [7]MemtoReg [8]Branch [9]Jump
//  alu_ctl   out  4   decoded ALU operation
//  result    out  W   ALU result
//  zero      out  1   result == 0
//  ovf       out  1   signed overflow (only with ALU_OVF_EN)
// BEHAVIOUR
//  - Fixed 1-cycle latency: inputs sampled on clk edge N appear on the outputs after edge N.
//  - rst=1 at an edge clears out_valid, ctrl, alu_ctl, result, zero and ovf to 0. rst has priority over every input.
//  - With in_valid=0, out_valid<=0 and the data outputs still update from the inputs; consumers ignore them.
//  - Main decode (ctrl, listed as bit0..bit9):
//      000000 R-type  1,1,0,1,0,0,0,0,0,0
//      100011 lw      0,1,1,0,0,1,0,1,0,0
//      101011 sw      0,0,1,0,0,0,1,0,0,0
//      000100 beq     0,0,0,0,1,0,0,0,1,0
//      000010 j       0,0,0,0,0,0,0,0,0,1
//      any other      all 0 (no write, no memory access, no branch or jump)
//  - ALU control:
//      ALUOp 00 -> 0010
//      ALUOp 01 -> 0110
//      ALUOp 10 -> by funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 100111->1100, 101010->0111, other->1111
//      ALUOp 11 -> 1111
//  - Operand B = ALUSrc ? {{16{imm16[15]}},imm16} : rdata2.
//  - ALU ops (A = rdata1):
//      0000 A&B
//      0001 A|B
//      0010 A+B (mod 2^W)
//      0110 A-B (mod 2^W)
//      0111 SLT: signed compare, result = {31'b0, A<B}
//      1100 ~(A|B)
//      1111 or any other code: result 0
//  - zero is computed from the same result, so an undefined op gives zero=1.
//  - No exceptions or traps. Add/sub wrap silently.
// CONFIGURATION
//  ALU_OVF_EN defined:
//    - ovf port exists.
//    - ovf=1 when 0010 has same-sign operands and the result sign differs.
//    - ovf=1 when 0110 has different-sign operands and the result sign differs from A.
//    - ovf=0 for all other ops. Reset value 0.
//    - result is still written.
//  ALU_OVF_EN undefined: ovf port is absent and no overflow logic is built.
// TESTING
//  1. rst=1 for 2 edges with random inputs -> all outputs 0. Release rst -> the next edge reflects the inputs.
//  2. R-add: opcode 0, funct 100000, A=5, B=7
//     -> ctrl bits0..9 = 1101000000, alu_ctl 0010, result 12, zero 0, out_valid 1 after one edge.
//  3. lw: opcode 100011, A=0x100, imm16=0xFFFC
//     -> ALUSrc=1, alu_ctl 0010, result 0xFC. sw with the same fields -> MemWrite=1, RegWrite=0.
//  4. beq: opcode 000100, A=B=0x1234 -> alu_ctl 0110, result 0, zero 1, Branch 1. With B=0x1235 -> zero 0.
//  5. SLT: A=0xFFFFFFFF, B=1 -> result 1. NOR: A=0, B=0 -> 0xFFFFFFFF.
//     Bad funct 111111 -> alu_ctl 1111, result 0, zero 1.
//  6. ALU_OVF_EN: add 0x7FFFFFFF+1 -> result 0x80000000, ovf 1.
//     sub 0x80000000-1 -> ovf 1. Opcode 111111 -> ctrl 0.

Source files
------------

// File: rtl/mips_exec_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mips_exec_decode
//  Description : Main decoder, ALU-control decoder and W-bit ALU for the
//                single-issue MIPS core. Every output is registered, so this
//                block also forms the decode/execute boundary register.
//                Latency is exactly one clock.
//  Ports       : clk, rst (sync, active-high)
//                in_valid, opcode[5:0], funct[5:0], imm16[15:0],
//                rdata1[W-1:0] (operand A), rdata2[W-1:0] (rt value)
//                out_valid, ctrl[9:0], alu_ctl[3:0], result[W-1:0], zero,
//                ovf (only when ALU_OVF_EN is defined)
//  ctrl bits   : [0]RegDst [1]RegWrite [2]ALUSrc [3]ALUOp1 [4]ALUOp0
//                [5]MemRead [6]MemWrite [7]MemtoReg [8]Branch [9]Jump
//  Options     : ALU_OVF_EN - adds the signed-overflow output ovf
//  Revision    : 1.0  initial release
// ============================================================================
module mips_exec_decode #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic [15:0]  imm16,
    input  logic [W-1:0] rdata1,
    input  logic [W-1:0] rdata2,
    output logic         out_valid,
    output logic [9:0]   ctrl,
    output logic [3:0]   alu_ctl,
    output logic [W-1:0] result,
`ifdef ALU_OVF_EN
    output logic         ovf,
`endif
    output logic         zero
);

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_NOR = 4'b1100;
    localparam logic [3:0] c_ALU_BAD = 4'b1111;

    logic [9:0]   w_ctrl;
    logic [1:0]   w_aluop;
    logic [3:0]   w_alu_ctl;
    logic [W-1:0] w_b;
    logic [W-1:0] w_result;

    // Main decoder: unknown opcodes decode to an all-zero (inert) control word.
    always_comb begin
        w_ctrl = 10'b0;
        case (opcode)
            6'b000000: w_ctrl = 10'b00_0000_1011; // R-type
            6'b100011: w_ctrl = 10'b00_1010_0110; // lw
            6'b101011: w_ctrl = 10'b00_0100_0100; // sw
            6'b000100: w_ctrl = 10'b01_0001_0000; // beq
            6'b000010: w_ctrl = 10'b10_0000_0000; // j
            default:   w_ctrl = 10'b0;
        endcase
    end

    // ALUOp1 lives in bit 3, ALUOp0 in bit 4.
    assign w_aluop = {w_ctrl[3], w_ctrl[4]};

    always_comb begin
        w_alu_ctl = c_ALU_BAD;
        case (w_aluop)
            2'b00: w_alu_ctl = c_ALU_ADD;
            2'b01: w_alu_ctl = c_ALU_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: w_alu_ctl = c_ALU_ADD;
                    6'b100010: w_alu_ctl = c_ALU_SUB;
                    6'b100100: w_alu_ctl = c_ALU_AND;
                    6'b100101: w_alu_ctl = c_ALU_OR;
                    6'b100111: w_alu_ctl = c_ALU_NOR;
                    6'b101010: w_alu_ctl = c_ALU_SLT;
                    default:   w_alu_ctl = c_ALU_BAD;
                endcase
            end
            default: w_alu_ctl = c_ALU_BAD;
        endcase
    end

    assign w_b = w_ctrl[2] ? {{(W-16){imm16[15]}}, imm16} : rdata2;

    // Undefined ALU codes produce 0, which in turn raises zero.
    always_comb begin
        w_result = '0;
        case (w_alu_ctl)
            c_ALU_AND: w_result = rdata1 & w_b;
            c_ALU_OR:  w_result = rdata1 | w_b;
            c_ALU_ADD: w_result = rdata1 + w_b;
            c_ALU_SUB: w_result = rdata1 - w_b;
            c_ALU_SLT: w_result = {{(W-1){1'b0}}, ($signed(rdata1) < $signed(w_b))};
            c_ALU_NOR: w_result = ~(rdata1 | w_b);
            default:   w_result = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow: add of like-signed operands, or sub of unlike-signed
    // operands, whose result sign differs from operand A.
    always_comb begin
        w_ovf = 1'b0;
        if (w_alu_ctl == c_ALU_ADD)
            w_ovf = (rdata1[W-1] == w_b[W-1]) && (w_result[W-1] != rdata1[W-1]);
        else if (w_alu_ctl == c_ALU_SUB)
            w_ovf = (rdata1[W-1] != w_b[W-1]) && (w_result[W-1] != rdata1[W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) r_ovf <= 1'b0;
        else     r_ovf <= w_ovf;
    end

    assign ovf = r_ovf;
`endif

    logic         r_out_valid;
    logic [9:0]   r_ctrl;
    logic [3:0]   r_alu_ctl;
    logic [W-1:0] r_result;
    logic         r_zero;

    // Data outputs follow the inputs even when in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= 10'b0;
            r_alu_ctl   <= 4'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            r_ctrl      <= w_ctrl;
            r_alu_ctl   <= w_alu_ctl;
            r_result    <= w_result;
            r_zero      <= (w_result == '0);
        end
    end

    assign out_valid = r_out_valid;
    assign ctrl      = r_ctrl;
    assign alu_ctl   = r_alu_ctl;
    assign result    = r_result;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mips_exec_decode
//  Description : Directed self-checking bench for mips_exec_decode. Each
//                scenario task drives one vector, waits one edge and compares
//                {out_valid, ctrl, alu_ctl, zero, result} with a hand-computed
//                value (plus ovf when ALU_OVF_EN is defined).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_exec_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        out_valid;
    logic [9:0]  ctrl;
    logic [3:0]  alu_ctl;
    logic [31:0] result;
    logic        zero;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mips_exec_decode #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .funct     (funct),
        .imm16     (imm16),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .out_valid (out_valid),
        .ctrl      (ctrl),
        .alu_ctl   (alu_ctl),
        .result    (result),
`ifdef ALU_OVF_EN
        .ovf       (ovf),
`endif
        .zero      (zero)
    );

    // Observed outputs packed as {out_valid, ctrl, alu_ctl, zero, result}.
    wire [47:0] obs = {out_valid, ctrl, alu_ctl, zero, result};

    localparam logic [9:0] C_R   = 10'h00B;
    localparam logic [9:0] C_LW  = 10'h0A6;
    localparam logic [9:0] C_SW  = 10'h044;
    localparam logic [9:0] C_BEQ = 10'h110;
    localparam logic [9:0] C_J   = 10'h200;

    // Apply one vector, let one edge pass, then sample 1 ns later.
    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b);
        in_valid = v; opcode = op; funct = fn; imm16 = imm; rdata1 = a; rdata2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 6'($urandom), 6'($urandom), 16'($urandom), $urandom, $urandom);
            checks++;
            if (obs !== 48'h0) begin
                fails++;
                $display("FAIL reset_%0d: got %h, want %h", i, obs, 48'h0);
            end
`ifdef ALU_OVF_EN
            checks++;
            if (ovf !== 1'b0) begin
                fails++;
                $display("FAIL reset_ovf_%0d: got %b, want 0", i, ovf);
            end
`endif
        end
        rst = 1'b0;
        drive(1'b1, 6'b000000, 6'b100000, 16'h0000, 32'd1, 32'd2);
        checks++;
        if (obs !== {1'b1, C_R, 4'h2, 1'b0, 32'd3}) begin
            fails++;
            $display("FAIL reset_release: got %h, want %h", obs, {1'b1, C_R, 4'h2, 1'b0, 32'd3});
        end
    endtask

    task automatic test_r_add();
        drive(1'b1, 6'b000000, 6'b100000, 16'h1234, 32'd5, 32'd7);
        checks++;
        if (obs !== {1'b1, C_R, 4'h2, 1'b0, 32'd12}) begin
            fails++;
            $display("FAIL r_add: got %h, want %h", obs, {1'b1, C_R, 4'h2, 1'b0, 32'd12});
        end
    endtask

    task automatic test_lw_sw();
        drive(1'b1, 6'b100011, 6'b000000, 16'hFFFC, 32'h100, 32'hDEAD);
        checks++;
        if (obs !== {1'b1, C_LW, 4'h2, 1'b0, 32'h0FC}) begin
            fails++;
            $display("FAIL lw_neg_imm: got %h, want %h", obs, {1'b1, C_LW, 4'h2, 1'b0, 32'h0FC});
        end
        drive(1'b1, 6'b101011, 6'b000000, 16'hFFFC, 32'h100, 32'hDEAD);
        checks++;
        if (obs !== {1'b1, C_SW, 4'h2, 1'b0, 32'h0FC}) begin
            fails++;
            $display("FAIL sw: got %h, want %h", obs, {1'b1, C_SW, 4'h2, 1'b0, 32'h0FC});
        end
        drive(1'b1, 6'b100011, 6'b000000, 16'h7FF8, 32'h100, 32'hDEAD);
        checks++;
        if (obs !== {1'b1, C_LW, 4'h2, 1'b0, 32'h80F8}) begin
            fails++;
            $display("FAIL lw_pos_imm: got %h, want %h", obs, {1'b1, C_LW, 4'h2, 1'b0, 32'h80F8});
        end
    endtask

    task automatic test_beq();
        drive(1'b1, 6'b000100, 6'b000000, 16'h0010, 32'h1234, 32'h1234);
        checks++;
        if (obs !== {1'b1, C_BEQ, 4'h6, 1'b1, 32'h0}) begin
            fails++;
            $display("FAIL beq_equal: got %h, want %h", obs, {1'b1, C_BEQ, 4'h6, 1'b1, 32'h0});
        end
        drive(1'b1, 6'b000100, 6'b000000, 16'h0010, 32'h1234, 32'h1235);
        checks++;
        if (obs !== {1'b1, C_BEQ, 4'h6, 1'b0, 32'hFFFF_FFFF}) begin
            fails++;
            $display("FAIL beq_unequal: got %h, want %h", obs, {1'b1, C_BEQ, 4'h6, 1'b0, 32'hFFFF_FFFF});
        end
    endtask

    task automatic test_r_ops();
        drive(1'b1, 6'b000000, 6'b100100, 16'h0, 32'hF0F0_1234, 32'h0FF0_FF00);
        checks++;
        if (obs !== {1'b1, C_R, 4'h0, 1'b0, 32'h00F0_1200}) begin
            fails++;
            $display("FAIL r_and: got %h, want %h", obs, {1'b1, C_R, 4'h0, 1'b0, 32'h00F0_1200});
        end
        drive(1'b1, 6'b000000, 6'b100101, 16'h0, 32'hF0F0_1234, 32'h0FF0_FF00);
        checks++;
        if (obs !== {1'b1, C_R, 4'h1, 1'b0, 32'hFFF0_FF34}) begin
            fails++;
            $display("FAIL r_or: got %h, want %h", obs, {1'b1, C_R, 4'h1, 1'b0, 32'hFFF0_FF34});
        end
        drive(1'b1, 6'b000000, 6'b100010, 16'h0, 32'd5, 32'd7);
        checks++;
        if (obs !== {1'b1, C_R, 4'h6, 1'b0, 32'hFFFF_FFFE}) begin
            fails++;
            $display("FAIL r_sub: got %h, want %h", obs, {1'b1, C_R, 4'h6, 1'b0, 32'hFFFF_FFFE});
        end
        drive(1'b1, 6'b000000, 6'b101010, 16'h0, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (obs !== {1'b1, C_R, 4'h7, 1'b0, 32'd1}) begin
            fails++;
            $display("FAIL slt_true: got %h, want %h", obs, {1'b1, C_R, 4'h7, 1'b0, 32'd1});
        end
        drive(1'b1, 6'b000000, 6'b101010, 16'h0, 32'd1, 32'hFFFF_FFFF);
        checks++;
        if (obs !== {1'b1, C_R, 4'h7, 1'b1, 32'd0}) begin
            fails++;
            $display("FAIL slt_false: got %h, want %h", obs, {1'b1, C_R, 4'h7, 1'b1, 32'd0});
        end
        drive(1'b1, 6'b000000, 6'b100111, 16'h0, 32'd0, 32'd0);
        checks++;
        if (obs !== {1'b1, C_R, 4'hC, 1'b0, 32'hFFFF_FFFF}) begin
            fails++;
            $display("FAIL r_nor: got %h, want %h", obs, {1'b1, C_R, 4'hC, 1'b0, 32'hFFFF_FFFF});
        end
        drive(1'b1, 6'b000000, 6'b111111, 16'h0, 32'd9, 32'd4);
        checks++;
        if (obs !== {1'b1, C_R, 4'hF, 1'b1, 32'd0}) begin
            fails++;
            $display("FAIL bad_funct: got %h, want %h", obs, {1'b1, C_R, 4'hF, 1'b1, 32'd0});
        end
    endtask

    task automatic test_jump_other();
        drive(1'b1, 6'b000010, 6'b100010, 16'hFFFF, 32'd3, 32'd4);
        checks++;
        if (obs !== {1'b1, C_J, 4'h2, 1'b0, 32'd7}) begin
            fails++;
            $display("FAIL jump: got %h, want %h", obs, {1'b1, C_J, 4'h2, 1'b0, 32'd7});
        end
        drive(1'b1, 6'b111111, 6'b100010, 16'hFFFF, 32'd3, 32'd4);
        checks++;
        if (obs !== {1'b1, 10'h000, 4'h2, 1'b0, 32'd7}) begin
            fails++;
            $display("FAIL unknown_opcode: got %h, want %h", obs, {1'b1, 10'h000, 4'h2, 1'b0, 32'd7});
        end
    endtask

    task automatic test_invalid();
        drive(1'b0, 6'b000000, 6'b100000, 16'h0, 32'd1, 32'd1);
        checks++;
        if (obs !== {1'b0, C_R, 4'h2, 1'b0, 32'd2}) begin
            fails++;
            $display("FAIL in_valid_low: got %h, want %h", obs, {1'b0, C_R, 4'h2, 1'b0, 32'd2});
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 6'b000000, 6'b100000, 16'h0, 32'd100, 32'd23);
        checks++;
        if (obs !== {1'b1, C_R, 4'h2, 1'b0, 32'd123}) begin
            fails++;
            $display("FAIL b2b_0: got %h, want %h", obs, {1'b1, C_R, 4'h2, 1'b0, 32'd123});
        end
        drive(1'b1, 6'b101011, 6'b0, 16'h0004, 32'h2000, 32'h0);
        checks++;
        if (obs !== {1'b1, C_SW, 4'h2, 1'b0, 32'h2004}) begin
            fails++;
            $display("FAIL b2b_1: got %h, want %h", obs, {1'b1, C_SW, 4'h2, 1'b0, 32'h2004});
        end
        rst = 1'b1;
        drive(1'b1, 6'b000000, 6'b100000, 16'h0, 32'd1, 32'd1);
        checks++;
        if (obs !== 48'h0) begin
            fails++;
            $display("FAIL b2b_reset: got %h, want %h", obs, 48'h0);
        end
        rst = 1'b0;
    endtask

`ifdef ALU_OVF_EN
    task automatic test_ovf();
        drive(1'b1, 6'b000000, 6'b100000, 16'h0, 32'h7FFF_FFFF, 32'd1);
        checks++;
        if ({ovf, result} !== {1'b1, 32'h8000_0000}) begin
            fails++;
            $display("FAIL ovf_add: got %b/%h, want 1/80000000", ovf, result);
        end
        drive(1'b1, 6'b000000, 6'b100010, 16'h0, 32'h8000_0000, 32'd1);
        checks++;
        if ({ovf, result} !== {1'b1, 32'h7FFF_FFFF}) begin
            fails++;
            $display("FAIL ovf_sub: got %b/%h, want 1/7fffffff", ovf, result);
        end
        drive(1'b1, 6'b000000, 6'b100000, 16'h0, 32'd5, 32'd7);
        checks++;
        if ({ovf, result} !== {1'b0, 32'd12}) begin
            fails++;
            $display("FAIL ovf_add_none: got %b/%h, want 0/0000000c", ovf, result);
        end
        drive(1'b1, 6'b000000, 6'b100101, 16'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        checks++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_or_none: got %b, want 0", ovf);
        end
        drive(1'b1, 6'b111111, 6'b0, 16'h0, 32'd0, 32'd0);
        checks++;
        if (ctrl !== 10'h000) begin
            fails++;
            $display("FAIL ovf_bad_opcode_ctrl: got %h, want 000", ctrl);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; opcode = '0; funct = '0; imm16 = '0;
        rdata1 = '0; rdata2 = '0;
        test_reset();
        test_r_add();
        test_lw_sw();
        test_beq();
        test_r_ops();
        test_jump_other();
        test_invalid();
        test_back_to_back();
`ifdef ALU_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
